// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core datapath and the word RAM.
// Takes one request at a time, drives the byte-strobed RAM (SB/SW only),
// splits SH into two byte writes, extends load data and returns a response
// with an error flag for misaligned or unsupported accesses.
module lsu_ctrl #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        weram,
  output logic        oeram,
  output logic [2:0]  func,
  output logic [1:0]  addr10,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ramout
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    EXEC_HI,
    RESP
  } state_t;

  state_t state, state_next;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        f3_legal;
  logic        misaligned;
  logic        req_bad;
  logic [31:0] addr_eff;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Classify the incoming request and, when misalignment is tolerated, clear the offending low address bits.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    addr_eff   = req_addr;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end
    if (req_funct3[1:0] == 2'b01) begin
      misaligned  = req_addr[0];
      addr_eff[0] = 1'b0;
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned    = |req_addr[1:0];
      addr_eff[1:0] = 2'b00;
    end
    req_bad = !f3_legal || (ERR_ON_MISALIGN && misaligned);
  end

  // Align the selected byte/half to bit 0 and sign- or zero-extend it according to the latched funct3.
  always_comb begin
    shifted = ramout >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // State register; reset always lands in IDLE on the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture on the accept edge and load data capture at the end of the EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
    end else if (req_valid && req_ready) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= addr_eff;
      wdata_q  <= req_wdata;
      rdata_q  <= 32'b0;
      err_q    <= req_bad;
    end else if (state == EXEC && !we_q) begin
      rdata_q  <= load_ext;
    end
  end

  // Next-state and output decode; reset forces every output low so no RAM write can happen on a reset edge.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'b0;
    rsp_err    = 1'b0;
    weram      = 1'b0;
    oeram      = 1'b0;
    func       = 3'b000;
    addr10     = 2'b00;
    ram_addr   = 32'b0;
    ram_wdata  = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_bad ? RESP : EXEC;
        end
      end
      EXEC: begin
        ram_addr = {2'b00, addr_q[31:2]};
        if (we_q) begin
          weram = 1'b1;
          case (funct3_q)
            3'b010: begin
              func       = 3'b010;
              addr10     = 2'b00;
              ram_wdata  = wdata_q;
              state_next = RESP;
            end
            3'b001: begin
              func       = 3'b000;
              addr10     = addr_q[1:0];
              ram_wdata  = {24'b0, wdata_q[7:0]};
              state_next = EXEC_HI;
            end
            default: begin
              func       = 3'b000;
              addr10     = addr_q[1:0];
              ram_wdata  = wdata_q;
              state_next = RESP;
            end
          endcase
        end else begin
          oeram      = 1'b1;
          func       = funct3_q;
          addr10     = addr_q[1:0];
          state_next = RESP;
        end
      end
      EXEC_HI: begin
        weram      = 1'b1;
        func       = 3'b000;
        ram_addr   = {2'b00, addr_q[31:2]};
        addr10     = addr_q[1:0] + 2'd1;
        ram_wdata  = {24'b0, wdata_q[15:8]};
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      state_next = IDLE;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_rdata  = 32'b0;
      rsp_err    = 1'b0;
      weram      = 1'b0;
      oeram      = 1'b0;
      func       = 3'b000;
      addr10     = 2'b00;
      ram_addr   = 32'b0;
      ram_wdata  = 32'b0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a byte-strobed word RAM model
// and a log of every RAM write cycle.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        weram;
  logic        oeram;
  logic [2:0]  func;
  logic [1:0]  addr10;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ramout;

  int total_checks  = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  logic [31:0] mem [0:1023];
  int          wr_total = 0;
  int          rd_total = 0;
  logic [1:0]  log_addr10   [0:63];
  logic [2:0]  log_func     [0:63];
  logic [31:0] log_ram_addr [0:63];
  logic [31:0] log_wdata    [0:63];

  lsu_ctrl #(.ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .weram(weram),
    .oeram(oeram),
    .func(func),
    .addr10(addr10),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ramout(ramout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM: asynchronous read, rising-edge write of one byte (SB) or the whole word (SW).
  assign ramout = mem[ram_addr[9:0]];
  always @(posedge clk) begin
    if (weram) begin
      if (func == 3'b010) begin
        mem[ram_addr[9:0]] <= ram_wdata;
      end else if (func == 3'b000) begin
        mem[ram_addr[9:0]][8*addr10 +: 8] <= ram_wdata[7:0];
      end
    end
  end

  // Record every write cycle and count read cycles so expectations can inspect RAM traffic afterwards.
  always @(posedge clk) begin
    if (weram) begin
      log_addr10[wr_total % 64]   <= addr10;
      log_func[wr_total % 64]     <= func;
      log_ram_addr[wr_total % 64] <= ram_addr;
      log_wdata[wr_total % 64]    <= ram_wdata;
      wr_total <= wr_total + 1;
    end
    if (oeram) begin
      rd_total <= rd_total + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) begin
      passed_checks++;
    end else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finishResp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic doAccess(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_wr, input int exp_rd);
    int wr0;
    int rd0;
    int lat;
    wr0 = wr_total;
    rd0 = rd_total;
    applyStimulus(we, f3, addr, wdata, lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    checkOutput({tag, "_writes"}, wr_total - wr0, exp_wr);
    checkOutput({tag, "_reads"}, rd_total - rd0, exp_rd);
    finishResp(tag);
  endtask

  // Watchdog so the run always ends even if something stalls outside a bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int lat;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    rsp_ready  = 1'b0;

    // Reset: everything low while rst is high
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_weram", {31'b0, weram}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // SW 0x100 then LW 0x100
    base = wr_total;
    doAccess("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 0);
    checkOutput("sw100_func", {29'b0, log_func[base % 64]}, 32'h2);
    checkOutput("sw100_ram_addr", log_ram_addr[base % 64], 32'h40);
    checkOutput("sw100_addr10", {30'b0, log_addr10[base % 64]}, 32'h0);
    checkOutput("sw100_mem", mem[10'h40], 32'hDEADBEEF);
    doAccess("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 1);

    // SH 0x102 over 0x11223344, two byte writes at offsets 2 then 3
    doAccess("sw_pre", 1'b1, 3'b010, 32'h100, 32'h11223344, 2, 32'h0, 1'b0, 1, 0);
    base = wr_total;
    doAccess("sh102", 1'b1, 3'b001, 32'h102, 32'h0000A55A, 3, 32'h0, 1'b0, 2, 0);
    checkOutput("sh102_addr10_lo", {30'b0, log_addr10[base % 64]}, 32'h2);
    checkOutput("sh102_addr10_hi", {30'b0, log_addr10[(base + 1) % 64]}, 32'h3);
    checkOutput("sh102_wdata_lo", log_wdata[base % 64], 32'h5A);
    checkOutput("sh102_wdata_hi", log_wdata[(base + 1) % 64], 32'hA5);
    checkOutput("sh102_func_hi", {29'b0, log_func[(base + 1) % 64]}, 32'h0);
    doAccess("lw_sh", 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hA55A3344, 1'b0, 0, 1);

    // Load extraction from word 0x80FF7F01
    doAccess("sw200", 1'b1, 3'b010, 32'h200, 32'h80FF7F01, 2, 32'h0, 1'b0, 1, 0);
    doAccess("lb203", 1'b0, 3'b000, 32'h203, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 1);
    doAccess("lbu203", 1'b0, 3'b100, 32'h203, 32'h0, 2, 32'h00000080, 1'b0, 0, 1);
    doAccess("lh202", 1'b0, 3'b001, 32'h202, 32'h0, 2, 32'hFFFF80FF, 1'b0, 0, 1);
    doAccess("lhu200", 1'b0, 3'b101, 32'h200, 32'h0, 2, 32'h00007F01, 1'b0, 0, 1);

    // Errors: misaligned SW, illegal load funct3, illegal store funct3
    doAccess("sw101", 1'b1, 3'b010, 32'h101, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, 0);
    checkOutput("sw101_mem", mem[10'h40], 32'hA55A3344);
    doAccess("ld011", 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    doAccess("st100", 1'b1, 3'b100, 32'h100, 32'h12345678, 1, 32'h0, 1'b1, 0, 0);
    checkOutput("st100_mem", mem[10'h40], 32'hA55A3344);

    // SB at byte 1 then zero-extended readback
    base = wr_total;
    doAccess("sb201", 1'b1, 3'b000, 32'h201, 32'h000000CC, 2, 32'h0, 1'b0, 1, 0);
    checkOutput("sb201_addr10", {30'b0, log_addr10[base % 64]}, 32'h1);
    checkOutput("sb201_mem", mem[10'h80], 32'h80FFCC01);
    doAccess("lbu201", 1'b0, 3'b100, 32'h201, 32'h0, 2, 32'h000000CC, 1'b0, 0, 1);

    // Backpressure: response held for 5 cycles
    applyStimulus(1'b0, 3'b010, 32'h200, 32'h0, lat);
    checkOutput("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rdata", rsp_rdata, 32'h80FFCC01);
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    finishResp("bp");
    checkOutput("bp_rsp_valid_after", {31'b0, rsp_valid}, 32'd0);

    // Reset during the high byte of SH 0x300
    doAccess("sw300", 1'b1, 3'b010, 32'h300, 32'h0, 2, 32'h0, 1'b0, 1, 0);
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h300;
    req_wdata  = 32'h0000BBAA;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("shrst_exec_weram", {31'b0, weram}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("shrst_hi_addr10", {30'b0, addr10}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("shrst_weram_in_rst", {31'b0, weram}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("shrst_mem", mem[10'hC0], 32'h000000AA);
    checkOutput("shrst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("shrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("shrst_rsp_valid_later", {31'b0, rsp_valid}, 32'd0);
    doAccess("lw300", 1'b0, 3'b010, 32'h300, 32'h0, 2, 32'h000000AA, 1'b0, 0, 1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core datapath and the word RAM (`weram`/`oeram`/`func`/`addr10` interface, async read, rising-edge byte-strobed write, SB/SW only).
- Accepts one memory request at a time over a valid/ready handshake and drives the RAM control and data lines.
- Splits SH into two SB cycles and extracts/extends load data (LB/LH/LW/LBU/LHU).
- Returns the result over a valid/ready response channel, with an error flag for misaligned or unsupported accesses.

Parameters:
- ERR_ON_MISALIGN, 1: when 1, misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0) return `rsp_err=1` and skip the RAM. When 0, the offending low address bits are forced to 0 and the access proceeds.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned or unsupported funct3
- weram  out  1  RAM write enable
- oeram  out  1  RAM output enable (loads)
- func  out  3  funct3 to RAM (000 SB or 010 SW for stores; request funct3 for loads)
- addr10  out  2  RAM byte offset
- ram_addr  out  32  RAM word index = byte address >> 2, zero-extended
- ram_wdata  out  32  RAM store data (R2)
- ramout  in  32  RAM async read word

Behaviour:
- Reset: synchronous and active-high. While `rst`=1, all outputs are driven 0, including `req_ready` and `weram`, so no write occurs on an edge where `rst`=1. The following edge lands in IDLE.
- Reset mid-operation aborts the request. An SH aborted after its low byte leaves that byte written, and no response is issued.
- FSM states: IDLE, EXEC, EXEC_HI, RESP.
- Request capture:
  - `req_ready` = (state==IDLE) && !rst.
  - On `req_valid && req_ready`, latch `we`, `funct3`, `addr`, `wdata`.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Illegal funct3, or misaligned with ERR_ON_MISALIGN=1: IDLE -> RESP with err=1, rdata=0, and no RAM activity.
- Otherwise IDLE -> EXEC.
- RAM outputs are driven only in EXEC/EXEC_HI; in all other states `weram`, `oeram`, `func`, `addr10`, `ram_addr`, `ram_wdata` are 0.
- EXEC, load:
  - `oeram`=1, `func`=funct3, `ram_addr`=addr>>2, `addr10`=addr[1:0].
  - Capture and extend `ramout` into the rdata register at the end of the cycle, then go to RESP.
  - Extraction: byte = ramout[8*a +: 8], half = ramout[8*a +: 16] (a = addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the word as-is.
- EXEC, SB: `weram`=1, `func`=000, `addr10`=a, `ram_wdata`=wdata. Go to RESP.
- EXEC, SW: `weram`=1, `func`=010, `addr10`=0, `ram_wdata`=wdata. Go to RESP.
- EXEC, SH: `weram`=1, `func`=000, `addr10`=a, `ram_wdata`={24'b0, wdata[7:0]}. Go to EXEC_HI.
- EXEC_HI (SH only): `weram`=1, `func`=000, `addr10`=a+1, `ram_wdata`={24'b0, wdata[15:8]}. Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_rdata`/`rsp_err` are stable while held.
  - On `rsp_ready`=1 go to IDLE; otherwise hold indefinitely.
- Latency from the accept edge to `rsp_valid`:
  - 2 cycles for loads, SB, SW.
  - 3 cycles for SH.
  - 1 cycle for errors.
- Throughput: a new request can be accepted the cycle after the response handshake. No request overlap.
- `rsp_err`=0 and `rsp_rdata`=0 for successful stores.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, then LW 0x100 -> `weram` high 1 cycle with `ram_addr`=0x40 and `func`=010; LW returns `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` 2 cycles after accept.
- SH addr=0x102, wdata=0x0000A55A over word 0x11223344, then LW 0x100 -> two SB cycles with `addr10`=2 then 3; readback 0xA55A3344; `rsp_valid` 3 cycles after accept.
- Word 0x80FF7F01 at 0x200: LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080; LH 0x202 -> 0xFFFF80FF; LHU 0x200 -> 0x00007F01.
- ERR_ON_MISALIGN=1: SW 0x101 -> `rsp_err`=1 one cycle after accept, `weram` never asserted, memory unchanged. LW funct3=011 -> `rsp_err`=1, `rsp_rdata`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after LW -> `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout; `req_ready`=1 the cycle after `rsp_ready`=1.
- Reset in EXEC_HI of SH 0x300 (wdata=0xBBAA over 0x00000000) -> `weram`=0 in the reset cycle, word reads 0x000000AA, no `rsp_valid`, `req_ready`=1 the cycle after `rst` deasserts.
